// File: rtl/seq_v74x148_enc.sv
// Clocked 74x148-style priority encoder: falling request edges are latched into PEND,
// and the highest pending index is held as an active-low code until ACK.
module seq_v74x148_enc #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          RST_L,
    input  logic          EI_L,
    input  logic [N-1:0]  I_L,
    input  logic          ACK,
    output logic [AW-1:0] A_L,
    output logic          GS_L,
    output logic          EO_L,
    output logic [N-1:0]  PEND,
    output logic          DBG_HOLD
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  req_q, req_d;
    logic [N-1:0]  clr;
    logic [AW-1:0] code_q, code_d;
    logic [AW-1:0] a_l_q, a_l_d;
    logic          gs_l_q, gs_l_d;
    logic [AW-1:0] top_idx;

    // Disabled lines read as "not requested", so req_q drops and a held line re-captures later.
    assign req_d = EI_L ? '0 : ~I_L;

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) top_idx = AW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        a_l_d   = a_l_q;
        gs_l_d  = gs_l_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    code_d  = top_idx;
                    a_l_d   = ~top_idx;
                    gs_l_d  = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ACK) begin
                    clr     = N'(1) << code_q;
                    a_l_d   = '1;
                    gs_l_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // New edges are OR-ed in after the clear, so a same-cycle set wins.
    assign pend_d = (pend_q & ~clr) | (req_d & ~req_q);

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            req_q   <= '0;
            code_q  <= '0;
            a_l_q   <= '1;
            gs_l_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            code_q  <= code_d;
            a_l_q   <= a_l_d;
            gs_l_q  <= gs_l_d;
        end
    end

    assign A_L      = a_l_q;
    assign GS_L     = gs_l_q;
    assign PEND     = pend_q;
    assign EO_L     = ~(~EI_L & (pend_q == '0) & (state_q == S_IDLE));
    assign DBG_HOLD = (state_q == S_HOLD);

endmodule
